// File: rtl/target_reset_sequencer.sv
// Target reset sequencer: on a reset request it holds the target in reset
// for HOLD_CYCLES and then waits SETTLE_CYCLES before reporting completion.
// Optional feature macro: RESET_TIMING_EN adds a boot-latency measurement
// from reset release to the first falling edge on the target's UART TX line.
module target_reset_sequencer #(
  parameter int unsigned SYSTEM_CLOCK   = 32000000,
  parameter int unsigned HOLD_CYCLES    = 3200,
  parameter int unsigned SETTLE_CYCLES  = 32000,
  parameter int unsigned TIMEOUT_CYCLES = 32000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trig_n,
  input  logic        target_rx,
  output logic        target_rst_n,
  output logic        busy,
  output logic        done,
  output logic [15:0] rst_count
`ifdef RESET_TIMING_EN
  ,
  output logic        t_valid,
  output logic [23:0] t_cycles
`endif
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             seq_start;    // IDLE -> HOLD this cycle
  logic             seq_release;  // HOLD -> SETTLE this cycle
  logic             seq_finish;   // SETTLE -> IDLE this cycle

  // SYSTEM_CLOCK is informational only.
  logic [31:0] unused_cfg;
  assign unused_cfg = SYSTEM_CLOCK ^ TIMEOUT_CYCLES;

  // Next-state and phase-counter logic.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next  = state;
    cnt_next    = cnt;
    seq_start   = 1'b0;
    seq_release = 1'b0;
    seq_finish  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!trig_n) begin
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
          seq_start  = 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_next  = SETTLE;
          cnt_next    = SETTLE_LOAD;
          seq_release = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_next = IDLE;
          seq_finish = 1'b1;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and phase-counter registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Registered outputs, decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      target_rst_n <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      rst_count    <= '0;
    end else begin
      target_rst_n <= (state_next != HOLD);
      busy         <= (state_next != IDLE);
      done         <= seq_finish;
      if (seq_start) rst_count <= rst_count + 16'd1;
    end
  end

`ifdef RESET_TIMING_EN
  // The measurement counter is 24 bits; clamp the limit so FFFFFF stays the timeout marker.
  localparam int unsigned TIMEOUT_EFF  = (TIMEOUT_CYCLES > 32'hFFFFFE) ? 32'hFFFFFE : TIMEOUT_CYCLES;
  localparam logic [23:0] TIMEOUT_LAST = 24'(TIMEOUT_EFF - 1);

  logic        rx_meta, rx_sync, rx_prev;
  logic        rx_fall;
  logic        meas_on;
  logic [23:0] meas_cnt;

  assign rx_fall = rx_prev & ~rx_sync;

  // Synchronize target_rx and time release-to-first-falling-edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      meas_on  <= 1'b0;
      meas_cnt <= '0;
      t_valid  <= 1'b0;
      t_cycles <= '0;
    end else begin
      rx_meta <= target_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      t_valid <= 1'b0;
      if (seq_start) begin
        meas_on <= 1'b0;
      end else if (seq_release) begin
        meas_on  <= 1'b1;
        meas_cnt <= '0;
      end else if (meas_on) begin
        if (rx_fall) begin
          t_cycles <= meas_cnt;
          t_valid  <= 1'b1;
          meas_on  <= 1'b0;
        end else if (meas_cnt == TIMEOUT_LAST) begin
          t_cycles <= 24'hFFFFFF;
          t_valid  <= 1'b1;
          meas_on  <= 1'b0;
        end else begin
          meas_cnt <= meas_cnt + 24'd1;
        end
      end
    end
  end
`else
  // Without the measurement, target_rx and the release event have no load.
  logic unused_rx;
  assign unused_rx = target_rx ^ seq_release;
`endif

endmodule

// File: tb/tb_target_reset_sequencer.sv
// Scoreboard bench for target_reset_sequencer (HOLD=4, SETTLE=8, TIMEOUT=50).
// Cycle numbers in each test are relative to the cycle reset is released.
module tb_target_reset_sequencer;

  localparam int HOLD   = 4;
  localparam int SETTLE = 8;
  localparam int TMO    = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        trig_n;
  logic        target_rx;
  logic        target_rst_n;
  logic        busy;
  logic        done;
  logic [15:0] rst_count;
`ifdef RESET_TIMING_EN
  logic        t_valid;
  logic [23:0] t_cycles;
`endif

  target_reset_sequencer #(
    .SYSTEM_CLOCK  (32000000),
    .HOLD_CYCLES   (HOLD),
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .trig_n      (trig_n),
    .target_rx   (target_rx),
    .target_rst_n(target_rst_n),
    .busy        (busy),
    .done        (done),
    .rst_count   (rst_count)
`ifdef RESET_TIMING_EN
    ,
    .t_valid     (t_valid),
    .t_cycles    (t_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    logic [18:0] val;   // {target_rst_n, busy, done, rst_count}
    string       tag;
  } port_exp_t;

  typedef struct {
    int          at;
    logic [23:0] val;
  } time_exp_t;

  port_exp_t sq[$];
  time_exp_t tq[$];
  port_exp_t pe;
  time_exp_t te;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t0    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected port values at relative cycle c for sequences triggered at n0..n2 (-1 = none).
  function automatic logic [18:0] model(input int c, input int n0, input int n1, input int n2,
                                        input logic [15:0] base);
    int          ns[3];
    logic        trn;
    logic        bsy;
    logic        dn;
    logic [15:0] cnt;
    ns[0] = n0; ns[1] = n1; ns[2] = n2;
    trn = 1'b1; bsy = 1'b0; dn = 1'b0; cnt = base;
    for (int i = 0; i < 3; i++) begin
      if (ns[i] >= 0) begin
        if (c >= ns[i] + 1 && c <= ns[i] + HOLD)          trn = 1'b0;
        if (c >= ns[i] + 1 && c <= ns[i] + HOLD + SETTLE) bsy = 1'b1;
        if (c == ns[i] + HOLD + SETTLE + 1)               dn  = 1'b1;
        if (c >= ns[i] + 1)                               cnt = cnt + 16'd1;
      end
    end
    return {trn, bsy, dn, cnt};
  endfunction

  task automatic push_window(input string tag, input int lo, input int hi,
                             input int n0, input int n1, input int n2, input logic [15:0] base);
    for (int c = lo; c <= hi; c++)
      sq.push_back('{t0 + c, model(c, n0, n1, n2, base), $sformatf("%s@%0d", tag, c)});
  endtask

  task automatic goto(input int rel);
    while (cyc < t0 + rel) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    trig_n    = 1'b1;
    target_rx = 1'b1;
    sq.push_back('{cyc + 1, {1'b1, 1'b0, 1'b0, 16'h0000}, "reset"});
    @(posedge clk);
    #1;
`ifdef RESET_TIMING_EN
    @(negedge clk);
    check("reset_t_valid", t_valid, 1'b0);
    check("reset_t_cycles", t_cycles, 24'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;
    t0  = cyc;
  endtask

  // Scoreboard monitor: pop and compare expectations on the falling edge.
  always @(negedge clk) begin
    while (sq.size() != 0 && sq[0].at <= cyc) begin
      pe = sq.pop_front();
      if (pe.at != cyc) check({pe.tag, "_late"}, cyc, pe.at);
      else check(pe.tag, {target_rst_n, busy, done, rst_count}, pe.val);
    end
`ifdef RESET_TIMING_EN
    if (t_valid === 1'b1) begin
      if (tq.size() == 0) begin
        check("t_valid_unexpected", t_valid, 1'b0);
      end else begin
        te = tq.pop_front();
        check("t_valid_cycle", cyc - t0, te.at - t0);
        check("t_cycles", t_cycles, te.val);
      end
    end
`endif
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    trig_n    = 1'b1;
    target_rx = 1'b1;
    @(posedge clk);
    #1;

    // Single-cycle request at 10.
    do_reset();
    push_window("single", 5, 30, 10, -1, -1, 16'h0000);
    goto(10); trig_n = 1'b0;
    goto(11); trig_n = 1'b1;
    goto(31);

    // Requests during HOLD and SETTLE are dropped.
    do_reset();
    push_window("ignored", 5, 30, 10, -1, -1, 16'h0000);
    goto(10); trig_n = 1'b0;
    goto(11); trig_n = 1'b1;
    goto(13); trig_n = 1'b0;
    goto(14); trig_n = 1'b1;
    goto(20); trig_n = 1'b0;
    goto(21); trig_n = 1'b1;
    goto(31);

    // Request held low 10..40 restarts in each done cycle (23, 36).
    do_reset();
    push_window("held", 5, 52, 10, 23, 36, 16'h0000);
    goto(10); trig_n = 1'b0;
    goto(41); trig_n = 1'b1;
    goto(53);

    // Reset at 12 during HOLD abandons the sequence; trig_n ignored under reset.
    do_reset();
    for (int c = 5; c <= 30; c++)
      sq.push_back('{t0 + c,
                     (c >= 11 && c <= 12) ? {1'b0, 1'b1, 1'b0, 16'h0001}
                                          : {1'b1, 1'b0, 1'b0, 16'h0000},
                     $sformatf("midreset@%0d", c)});
    goto(10); trig_n = 1'b0;
    goto(11); trig_n = 1'b1;
    goto(12); rst = 1'b0; trig_n = 1'b0;
    goto(13); rst = 1'b1; trig_n = 1'b1;
    goto(31);

    // Counter wraps from FFFF to 0.
    do_reset();
    push_window("wrap", 8, 30, 10, -1, -1, 16'hFFFF);
    goto(5); force dut.rst_count = 16'hFFFF;
    goto(6); release dut.rst_count;
    goto(10); trig_n = 1'b0;
    goto(11); trig_n = 1'b1;
    goto(31);

`ifdef RESET_TIMING_EN
    // Release R=15, target_rx falls at R+20 -> t_cycles=22 visible at R+23; later edges ignored.
    do_reset();
    push_window("meas", 5, 30, 10, -1, -1, 16'h0000);
    tq.push_back('{t0 + 38, 24'd22});
    goto(10); trig_n = 1'b0;
    goto(11); trig_n = 1'b1;
    goto(35); target_rx = 1'b0;
    goto(45); target_rx = 1'b1;
    goto(50); target_rx = 1'b0;
    goto(55); target_rx = 1'b1;
    goto(90);
    check("meas_pending", tq.size(), 0);

    // No falling edge -> timeout marker at R+50.
    do_reset();
    tq.push_back('{t0 + 65, 24'hFFFFFF});
    goto(10); trig_n = 1'b0;
    goto(11); trig_n = 1'b1;
    goto(70); target_rx = 1'b0;
    goto(75); target_rx = 1'b1;
    goto(90);
    check("timeout_pending", tq.size(), 0);
`endif

    goto(92);
    check("scoreboard_drained", sq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
